// File: rtl/ku040_rst_seq.sv
// ku040_rst_seq: reset / clock bring-up sequencer for the KU040 board clocking.
// Pulses the MMCM reset, waits for lock with a retry timeout, then releases
// GT_RST and USER_RST in order once lock has been stable. Any lock loss
// restarts the sequence.
// Optional feature: define KU040_RST_SEQ_FAIL_EN to add a terminal FAIL state
// entered once RETRY_CNT reaches MAX_RETRY.
module ku040_rst_seq #(
   parameter int unsigned RST_CYCLES    = 255,
   parameter int unsigned LOCK_TIMEOUT  = 50000,
   parameter int unsigned SETTLE_CYCLES = 1024,
   parameter int unsigned GT_TO_USER    = 64,
   parameter int unsigned MAX_RETRY     = 8
) (
   input  logic       CLK250,
   input  logic       RST_N,
   input  logic       SOFT_RST,
   input  logic       DCM_LOCKED,
   output logic       DCM_RST,
   output logic       GT_RST,
   output logic       USER_RST,
   output logic       READY,
   output logic       FAIL,
   output logic [3:0] RETRY_CNT
);

   localparam logic [15:0] LD_RST    = 16'(RST_CYCLES - 1);
   localparam logic [15:0] LD_LOCK   = 16'(LOCK_TIMEOUT - 1);
   localparam logic [15:0] LD_SETTLE = 16'(SETTLE_CYCLES - 1);
   localparam logic [15:0] LD_GT     = 16'(GT_TO_USER - 1);

   if (MAX_RETRY < 1 || MAX_RETRY > 15 || RST_CYCLES < 1 || LOCK_TIMEOUT < 2 ||
       SETTLE_CYCLES < 1 || GT_TO_USER < 1 || RST_CYCLES > 65535 ||
       LOCK_TIMEOUT > 65535 || SETTLE_CYCLES > 65535 || GT_TO_USER > 65535) begin : g_bad_params
      $error("ku040_rst_seq: parameter out of range");
   end

   typedef enum logic [2:0] {
      S_RESET,
      S_WAIT_LOCK,
      S_SETTLE,
      S_GT_REL,
      S_RUN
`ifdef KU040_RST_SEQ_FAIL_EN
      , S_FAIL
`endif
   } state_t;

   state_t      state, state_nxt;
   logic [15:0] cnt, cnt_nxt;
   logic [3:0]  retry_nxt, retry_inc;
   logic        lk_meta, lk;
   logic        dcm_rst_d, gt_rst_d, user_rst_d, ready_d;

   // Two-flop synchronizer for the asynchronous MMCM lock.
   always_ff @(posedge CLK250 or negedge RST_N) begin
      if (!RST_N) begin
         lk_meta <= 1'b0;
         lk      <= 1'b0;
      end else begin
         lk_meta <= DCM_LOCKED;
         lk      <= lk_meta;
      end
   end

   // Next-state, counter and retry logic: SOFT_RST > lock loss > counter expiry.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      retry_nxt = RETRY_CNT;
      retry_inc = (RETRY_CNT == 4'hF) ? RETRY_CNT : RETRY_CNT + 4'd1;
      if (SOFT_RST) begin
         state_nxt = S_RESET;
         cnt_nxt   = LD_RST;
         retry_nxt = '0;
      end else begin
         unique case (state)
            S_RESET: begin
               if (cnt == '0) begin
                  state_nxt = S_WAIT_LOCK;
                  cnt_nxt   = LD_LOCK;
               end else begin
                  cnt_nxt = cnt - 16'd1;
               end
            end
            S_WAIT_LOCK: begin
               if (lk) begin
                  state_nxt = S_SETTLE;
                  cnt_nxt   = LD_SETTLE;
               end else if (cnt == '0) begin
                  retry_nxt = retry_inc;
`ifdef KU040_RST_SEQ_FAIL_EN
                  if (retry_inc == 4'(MAX_RETRY)) begin
                     state_nxt = S_FAIL;
                  end else begin
                     state_nxt = S_RESET;
                     cnt_nxt   = LD_RST;
                  end
`else
                  state_nxt = S_RESET;
                  cnt_nxt   = LD_RST;
`endif
               end else begin
                  cnt_nxt = cnt - 16'd1;
               end
            end
            S_SETTLE: begin
               if (!lk) begin
                  state_nxt = S_RESET;
                  cnt_nxt   = LD_RST;
               end else if (cnt == '0) begin
                  state_nxt = S_GT_REL;
                  cnt_nxt   = LD_GT;
               end else begin
                  cnt_nxt = cnt - 16'd1;
               end
            end
            S_GT_REL: begin
               if (!lk) begin
                  state_nxt = S_RESET;
                  cnt_nxt   = LD_RST;
               end else if (cnt == '0) begin
                  state_nxt = S_RUN;
                  retry_nxt = '0;
               end else begin
                  cnt_nxt = cnt - 16'd1;
               end
            end
            S_RUN: begin
               if (!lk) begin
                  state_nxt = S_RESET;
                  cnt_nxt   = LD_RST;
               end
            end
`ifdef KU040_RST_SEQ_FAIL_EN
            S_FAIL: begin
               state_nxt = S_FAIL;
            end
`endif
            default: begin
               state_nxt = S_RESET;
               cnt_nxt   = LD_RST;
            end
         endcase
      end
   end

   // Output decode from the next state, so the registered outputs always
   // match the state register they are loaded alongside.
   always_comb begin
      dcm_rst_d  = (state_nxt == S_RESET);
      gt_rst_d   = (state_nxt == S_RESET) || (state_nxt == S_WAIT_LOCK) ||
                   (state_nxt == S_SETTLE);
      user_rst_d = (state_nxt != S_RUN);
      ready_d    = (state_nxt == S_RUN);
`ifdef KU040_RST_SEQ_FAIL_EN
      if (state_nxt == S_FAIL) begin
         dcm_rst_d = 1'b1;
         gt_rst_d  = 1'b1;
      end
`endif
   end

   // State, counter, retry count and registered outputs.
   always_ff @(posedge CLK250 or negedge RST_N) begin
      if (!RST_N) begin
         state     <= S_RESET;
         cnt       <= LD_RST;
         RETRY_CNT <= '0;
         DCM_RST   <= 1'b1;
         GT_RST    <= 1'b1;
         USER_RST  <= 1'b1;
         READY     <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         RETRY_CNT <= retry_nxt;
         DCM_RST   <= dcm_rst_d;
         GT_RST    <= gt_rst_d;
         USER_RST  <= user_rst_d;
         READY     <= ready_d;
      end
   end

`ifdef KU040_RST_SEQ_FAIL_EN
   // Registered FAIL flag, set only while parked in the FAIL state.
   always_ff @(posedge CLK250 or negedge RST_N) begin
      if (!RST_N) begin
         FAIL <= 1'b0;
      end else begin
         FAIL <= (state_nxt == S_FAIL);
      end
   end
`else
   assign FAIL = 1'b0;
`endif

endmodule

// File: tb/tb_ku040_rst_seq.sv
// Directed bench for ku040_rst_seq. Expected output vectors
// {DCM_RST, GT_RST, USER_RST, READY, FAIL, RETRY_CNT} are queued when the
// stimulus is applied and popped/compared once the DUT reaches that point.
module tb_ku040_rst_seq;

   logic       CLK250 = 1'b0;
   logic       RST_N  = 1'b1;
   logic       SOFT_RST = 1'b0;
   logic       DCM_LOCKED = 1'b0;
   logic       DCM_RST, GT_RST, USER_RST, READY, FAIL;
   logic [3:0] RETRY_CNT;

   int unsigned errors = 0;
   int unsigned checks = 0;
   int unsigned n_to;

   string      tag_q[$];
   logic [8:0] exp_q[$];

   ku040_rst_seq #(
      .RST_CYCLES   (8),
      .LOCK_TIMEOUT (100),
      .SETTLE_CYCLES(16),
      .GT_TO_USER   (4),
      .MAX_RETRY    (3)
   ) dut (
      .CLK250    (CLK250),
      .RST_N     (RST_N),
      .SOFT_RST  (SOFT_RST),
      .DCM_LOCKED(DCM_LOCKED),
      .DCM_RST   (DCM_RST),
      .GT_RST    (GT_RST),
      .USER_RST  (USER_RST),
      .READY     (READY),
      .FAIL      (FAIL),
      .RETRY_CNT (RETRY_CNT)
   );

   always #5 CLK250 = ~CLK250;

   function automatic logic [8:0] RSTV(input logic [3:0] c);
      return {5'b11100, c};
   endfunction
   function automatic logic [8:0] WAITV(input logic [3:0] c);
      return {5'b01100, c};
   endfunction
   function automatic logic [8:0] GTV(input logic [3:0] c);
      return {5'b00100, c};
   endfunction
   function automatic logic [8:0] RUNV();
      return {5'b00010, 4'd0};
   endfunction
   function automatic logic [8:0] FAILV(input logic [3:0] c);
      return {5'b11101, c};
   endfunction

   task automatic tick(input int unsigned n);
      repeat (n) @(posedge CLK250);
      #1;
   endtask

   task automatic push(input string tag, input logic [8:0] e);
      tag_q.push_back(tag);
      exp_q.push_back(e);
   endtask

   task automatic pop_check();
      string      tag;
      logic [8:0] e;
      logic [8:0] o;
      o = {DCM_RST, GT_RST, USER_RST, READY, FAIL, RETRY_CNT};
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $error("FAIL scoreboard_empty observed=%b expected=<entry>", o);
      end else begin
         tag = tag_q.pop_front();
         e   = exp_q.pop_front();
         assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b (DCM,GT,USER,READY,FAIL,RETRY[3:0])", tag, o, e);
         end
      end
   endtask

   initial begin
      // Async reset with no clock edge yet.
      #1 RST_N = 1'b0;
      #1;
      push("por_values", RSTV(4'd0)); pop_check();
      tick(2);
      RST_N = 1'b1;

      // Nominal bring-up.
      push("dcm_rst_held", RSTV(4'd0));   tick(7);  pop_check();
      push("dcm_rst_fall", WAITV(4'd0));  tick(1);  pop_check();
      tick(20);
      DCM_LOCKED = 1'b1;
      push("settle_gt_held", WAITV(4'd0)); tick(18); pop_check();
      push("gt_rst_fall", GTV(4'd0));     tick(1);  pop_check();
      push("user_rst_held", GTV(4'd0));   tick(3);  pop_check();
      push("ready_rise", RUNV());         tick(1);  pop_check();

      // Lock loss in RUN, then relock.
      DCM_LOCKED = 1'b0;
      push("run_before_loss", RUNV());    tick(2);  pop_check();
      push("loss_resets", RSTV(4'd0));    tick(1);  pop_check();
      DCM_LOCKED = 1'b1;
      push("relock_dcm_fall", WAITV(4'd0)); tick(8);  pop_check();
      push("relock_gt_held", WAITV(4'd0)); tick(16); pop_check();
      push("relock_gt_fall", GTV(4'd0));  tick(1);  pop_check();
      push("relock_ready", RUNV());       tick(4);  pop_check();

      // SOFT_RST pulse from RUN, lock removed -> one timeout.
      SOFT_RST = 1'b1;
      DCM_LOCKED = 1'b0;
      push("soft_from_run", RSTV(4'd0));  tick(1);  pop_check();
      SOFT_RST = 1'b0;
      push("soft_dcm_held", RSTV(4'd0));  tick(7);  pop_check();
      push("soft_dcm_fall", WAITV(4'd0)); tick(1);  pop_check();
      push("timeout_pre", WAITV(4'd0));   tick(99); pop_check();
      push("timeout_first", RSTV(4'd1));  tick(1);  pop_check();

      // Lock glitch 10 cycles into SETTLE.
      DCM_LOCKED = 1'b1;
      push("glitch_setup", WAITV(4'd1));  tick(19); pop_check();
      DCM_LOCKED = 1'b0;
      tick(1);
      DCM_LOCKED = 1'b1;
      push("glitch_settle", WAITV(4'd1)); tick(1);  pop_check();
      push("glitch_reset", RSTV(4'd1));   tick(1);  pop_check();
      push("glitch_settle2", WAITV(4'd1)); tick(24); pop_check();
      push("glitch_gt_fall", GTV(4'd1));  tick(1);  pop_check();
      push("run_retry_clr", RUNV());      tick(4);  pop_check();

      // Repeated timeouts with lock held low.
      DCM_LOCKED = 1'b0;
      push("to_loss", RSTV(4'd0));        tick(3);  pop_check();
`ifdef KU040_RST_SEQ_FAIL_EN
      n_to = 3;
`else
      n_to = 16;
`endif
      for (int k = 1; k <= int'(n_to); k++) begin
         push("to_wait_end", WAITV(4'(k - 1))); tick(107); pop_check();
`ifdef KU040_RST_SEQ_FAIL_EN
         if (k == 3) push("to_fail", FAILV(4'd3));
         else        push("to_retry", RSTV(4'(k)));
`else
         push("to_retry", RSTV((k > 15) ? 4'd15 : 4'(k)));
`endif
         tick(1); pop_check();
      end
`ifdef KU040_RST_SEQ_FAIL_EN
      push("fail_sticky", FAILV(4'd3));   tick(200); pop_check();
`endif

      // SOFT_RST from FAIL / saturated retry.
      tick(18);
      SOFT_RST = 1'b1;
      push("soft_clear", RSTV(4'd0));     tick(1);  pop_check();
      SOFT_RST = 1'b0;
      push("soft2_dcm_held", RSTV(4'd0)); tick(7);  pop_check();
      push("soft2_dcm_fall", WAITV(4'd0)); tick(1); pop_check();

      // Async reset in the middle of GT_REL.
      DCM_LOCKED = 1'b1;
      push("gtrel_reached", GTV(4'd0));   tick(20); pop_check();
      #3 RST_N = 1'b0;
      #1;
      push("async_mid_gtrel", RSTV(4'd0)); pop_check();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ku040_rst_seq.md
# ku040_rst_seq

Reset and clock-bring-up sequencer for the KU040 board clocking. Runs on the free-running 250 MHz board clock. Drives the MMCM reset, watches its lock, and retries bring-up on timeout. Releases the GT and user-logic resets in a fixed order once the clocks are stable, and re-runs the sequence when lock is lost at any point.

## Interface
Parameters:
- RST_CYCLES, 255: MMCM reset pulse length in CLK250 cycles (≥1).
- LOCK_TIMEOUT, 50000: cycles allowed in WAIT_LOCK before a retry (≥2).
- SETTLE_CYCLES, 1024: consecutive locked cycles required before any reset is released (≥1).
- GT_TO_USER, 64: cycles between GT_RST release and USER_RST release (≥1).
- MAX_RETRY, 8: timeout retries before FAIL (1..15; used only with the macro).
- All cycle parameters must be < 2^16 (single 16-bit down-counter).

Ports:
- CLK250 in 1: free-running board clock.
- RST_N in 1: reset, **asynchronous, active-low**.
- SOFT_RST in 1: synchronous restart request, level-sensitive.
- DCM_LOCKED in 1: MMCM lock. Asynchronous to CLK250.
- DCM_RST out 1: MMCM reset, active-high.
- GT_RST out 1: transceiver reset, active-high.
- USER_RST out 1: user-logic reset, active-high.
- READY out 1: sequence complete, clocks stable.
- FAIL out 1: retry limit exhausted (0 when macro absent).
- RETRY_CNT out 4: timeout retries since last RUN entry, saturating at 15.

## Operation
- DCM_LOCKED passes through a 2-flop synchronizer; all decisions use the synchronized value LK.
- States: RESET, WAIT_LOCK, SETTLE, GT_REL, RUN, and FAIL (only with the macro).
- **RESET**
  - DCM_RST=1, GT_RST=1, USER_RST=1.
  - Counter loaded with RST_CYCLES-1.
  - Goes to WAIT_LOCK when the counter reaches 0.
- **WAIT_LOCK**
  - DCM_RST=0.
  - LK=1 → SETTLE.
  - Counter expires with LK=0 → RETRY_CNT+1, then go to RESET (or FAIL, see Configuration).
- **SETTLE**
  - LK=0 → RESET. RETRY_CNT is not incremented.
  - SETTLE_CYCLES consecutive cycles with LK=1 → GT_REL.
- **GT_REL**
  - GT_RST=0.
  - LK=0 → RESET.
  - After GT_TO_USER cycles → RUN.
- **RUN**
  - USER_RST=0, READY=1, RETRY_CNT cleared on entry.
  - LK=0 → RESET.
- Priority order: RST_N > SOFT_RST > LK loss > counter expiry.
- SOFT_RST=1 in any state → RESET on the next edge; RETRY_CNT and FAIL are cleared. While SOFT_RST is held, the FSM stays in RESET with the counter reloaded each cycle.
- Lock loss and counter expiry in the same cycle: lock loss wins. In WAIT_LOCK, LK=1 on the expiry cycle goes to SETTLE.

## Timing
- All outputs are registered and decoded from the state register.
- Values during RST_N low: DCM_RST=1, GT_RST=1, USER_RST=1, READY=0, FAIL=0, RETRY_CNT=0, state=RESET. The synchronizer is also cleared.
- Deassertion of RST_N is not synchronized inside this block; the caller supplies a clean RST_N.
- First edge after RST_N release: RESET counting begins. DCM_RST falls exactly RST_CYCLES cycles later.
- Lock-response latency: DCM_LOCKED rising → LK 2 cycles later → state change on the next edge. Falling lock behaves the same way.
- From LK=1 in WAIT_LOCK: GT_RST falls after SETTLE_CYCLES+1 cycles. USER_RST falls and READY rises together GT_TO_USER cycles after that.
- Lock loss in RUN: READY=0 and all three resets = 1 within 3 cycles of DCM_LOCKED falling. Resets assert together in one cycle, with no ordering.
- RETRY_CNT updates on the same edge as the WAIT_LOCK→RESET transition.

## Configuration
- KU040_RST_SEQ_FAIL_EN defined:
  - A timeout that makes RETRY_CNT equal MAX_RETRY goes to FAIL instead of RESET.
  - In FAIL: DCM_RST=1, GT_RST=1, USER_RST=1, READY=0, FAIL=1.
  - FAIL is left only via SOFT_RST or RST_N.
- KU040_RST_SEQ_FAIL_EN undefined:
  - No FAIL state; retries continue forever.
  - RETRY_CNT saturates at 15.
  - FAIL is tied to 0.

## Test plan
All scenarios use RST_CYCLES=8, LOCK_TIMEOUT=100, SETTLE_CYCLES=16, GT_TO_USER=4, MAX_RETRY=3.
- Nominal: RST_N released, DCM_LOCKED rises 20 cycles after DCM_RST falls → DCM_RST high exactly 8 cycles; GT_RST falls 19 cycles after the lock edge; USER_RST falls and READY rises 4 cycles after that; RETRY_CNT=0.
- Timeout: DCM_LOCKED held 0 → DCM_RST re-pulses every 108 cycles and RETRY_CNT counts 1,2,…. With the macro, FAIL=1 after the 3rd timeout and the block stays there. Without the macro, RETRY_CNT stops at 15 and FAIL stays 0.
- Lock glitch in SETTLE: DCM_LOCKED drops for 1 cycle 10 cycles into SETTLE → return to RESET, GT_RST stays 1, RETRY_CNT unchanged.
- Lock loss in RUN: drop DCM_LOCKED → READY=0 and all resets =1 within 3 cycles; with lock restored, the full sequence repeats.
- SOFT_RST from FAIL or RUN: 1-cycle pulse → state RESET next edge, FAIL=0, RETRY_CNT=0, DCM_RST=1 for 8 cycles.
- Async reset mid-GT_REL: RST_N low at any phase → all outputs take their reset values immediately, with no clock needed.
